// File: rtl/reg_exec_seq.sv
// Execute/control stage for a 16 x 8-bit register file: fetches operands, runs the ALU
// or an iterative shift-add multiply, and writes the result back through the write port.
module reg_exec_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] RA1,
  output logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] data_out1,
  input  logic [DATA_W-1:0] data_out2,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  output logic              done,
  output logic              err,
  output logic              zero,
  output logic              carry
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

  state_t                r_state, w_next;
  logic [15:0]           r_instr;
  logic [ADDR_W-1:0]     r_ra1, r_ra2, r_wa;
  logic [DATA_W-1:0]     r_result;
  logic                  r_carryPend, r_zero, r_carry;
  logic [2*DATA_W-1:0]   r_mcand, r_acc, w_accNext;
  logic [DATA_W-1:0]     r_mplier;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            w_op;
  logic [DATA_W:0]       w_sum;
  logic [DATA_W-1:0]     w_aluRes;
  logic                  w_aluCarry, w_illegal, w_mulLast;

  assign w_op      = r_instr[15:12];
  assign w_sum     = {1'b0, data_out1} + {1'b0, data_out2};
  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mulLast = (r_cnt == CNT_W'(DATA_W - 1));

  assign RA1     = r_ra1;
  assign RA2     = r_ra2;
  assign WA      = r_wa;
  assign data_in = r_result;
  assign zero    = r_zero;
  assign carry   = r_carry;

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    w_illegal  = 1'b0;
    case (w_op)
      4'd0, 4'd9: ;
      4'd1: {w_aluCarry, w_aluRes} = w_sum;
      4'd2: begin
        w_aluRes   = data_out1 - data_out2;
        w_aluCarry = (data_out1 < data_out2);
      end
      4'd3: w_aluRes = data_out1 & data_out2;
      4'd4: w_aluRes = data_out1 | data_out2;
      4'd5: w_aluRes = data_out1 ^ data_out2;
      4'd6: w_aluRes = data_out1 << data_out2[2:0];
      4'd7: w_aluRes = data_out1 >> data_out2[2:0];
      4'd8: w_aluRes = DATA_W'(r_instr[7:0]);
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    instr_ready  = 1'b0;
    write_enable = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_READ;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        if (w_op == 4'd0) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else if (w_op == 4'd9) begin
          w_next = S_MUL;
        end else if (w_illegal) begin
          err    = 1'b1;
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_WB;
        end
      end
      S_MUL: if (w_mulLast) w_next = S_WB;
      S_WB: begin
        write_enable = 1'b1;
        done         = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Multiplier consumes one bit per cycle LSB first; the final partial sum is taken
  // straight from w_accNext so WB follows the last MUL cycle without an extra stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr     <= '0;
      r_ra1       <= '0;
      r_ra2       <= '0;
      r_wa        <= '0;
      r_result    <= '0;
      r_carryPend <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_instr <= instr;
          r_ra1   <= instr[4 +: ADDR_W];
          r_ra2   <= instr[0 +: ADDR_W];
        end
        S_EXEC: begin
          r_wa        <= r_instr[8 +: ADDR_W];
          r_result    <= w_aluRes;
          r_carryPend <= w_aluCarry;
          r_mcand     <= {{DATA_W{1'b0}}, data_out1};
          r_mplier    <= data_out2;
          r_acc       <= '0;
          r_cnt       <= '0;
        end
        S_MUL: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mulLast) begin
            r_result    <= w_accNext[DATA_W-1:0];
            r_carryPend <= |w_accNext[2*DATA_W-1:DATA_W];
          end
        end
        S_WB: begin
          r_zero  <= (r_result == '0);
          r_carry <= r_carryPend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_exec_seq.sv
// Testbench for reg_exec_seq: behavioural register file plus a scoreboard of expected
// retirements predicted from a shadow copy of the registers and flags.
module tb_reg_exec_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  data_out1, data_out2, data_in;
  logic        write_enable, done, err, zero, carry;

  logic [7:0]  rf [16];
  logic [7:0]  shadow [16];
  logic        expZ, expC;
  int          checks, errors;

  typedef struct {
    logic       writes;
    logic [3:0] wa;
    logic [7:0] data;
    logic       err;
    logic       z;
    logic       c;
    int         lat;
  } exp_t;

  typedef struct {
    int         lat;
    logic       we;
    logic [3:0] wa;
    logic [7:0] data;
    logic       err;
    logic       stray;
    logic       ready;
    logic       z;
    logic       c;
    logic       after;
  } obs_t;

  exp_t sb[$];

  reg_exec_seq #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RA1(RA1), .RA2(RA2), .data_out1(data_out1),
    .data_out2(data_out2), .WA(WA), .data_in(data_in), .write_enable(write_enable),
    .done(done), .err(err), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  assign data_out1 = rf[RA1];
  assign data_out2 = rf[RA2];

  always @(posedge clk) if (write_enable) rf[WA] <= data_in;

  function automatic logic [8:0] modelAlu(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm);
    logic [15:0] p;
    case (op)
      4'd1: return {1'b0, a} + {1'b0, b};
      4'd2: return {a < b, 8'(a - b)};
      4'd3: return {1'b0, a & b};
      4'd4: return {1'b0, a | b};
      4'd5: return {1'b0, a ^ b};
      4'd6: return {1'b0, 8'(a << b[2:0])};
      4'd7: return {1'b0, a >> b[2:0]};
      4'd8: return {1'b0, imm};
      4'd9: begin
        p = {8'd0, a} * {8'd0, b};
        return {|p[15:8], p[7:0]};
      end
      default: return 9'd0;
    endcase
  endfunction

  function automatic exp_t predict(input logic [15:0] ins);
    exp_t       e;
    logic [3:0] op;
    logic [8:0] r;
    op       = ins[15:12];
    r        = modelAlu(op, shadow[ins[7:4]], shadow[ins[3:0]], ins[7:0]);
    e.writes = (op >= 4'd1) && (op <= 4'd9);
    e.err    = (op >= 4'd10);
    e.lat    = (op == 4'd9) ? 11 : ((op == 4'd0 || op >= 4'd10) ? 2 : 3);
    e.wa     = ins[11:8];
    e.data   = r[7:0];
    e.z      = e.writes ? (r[7:0] == 8'd0) : expZ;
    e.c      = e.writes ? r[8] : expC;
    return e;
  endfunction

  // Pushes the prediction, performs the handshake and records what the DUT does up to
  // and one cycle past its done pulse (bounded so a stuck DUT still reaches the summary).
  task automatic applyStimulus(input logic [15:0] ins, output obs_t o);
    sb.push_back(predict(ins));
    o = '{default: 0};
    o.lat = -1;
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        o.lat  = cyc;
        o.we   = write_enable;
        o.wa   = WA;
        o.data = data_in;
        o.err  = err;
        break;
      end else if (write_enable || err) begin
        o.stray = 1'b1;
      end
    end
    @(negedge clk);
    o.ready = instr_ready;
    o.z     = zero;
    o.c     = carry;
    o.after = done | err | write_enable;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr = 16'h8155;
    instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({RA1, RA2, WA, data_in} !== 20'd0)
      $display("[TB] FAIL reset_addr_data: got %h expected 0", {RA1, RA2, WA, data_in});
    checks++;
    if ({write_enable, done, err, zero, carry, instr_ready} !== 6'b000001)
      $display("[TB] FAIL reset_ctrl: got %b expected 000001",
               {write_enable, done, err, zero, carry, instr_ready});
    if ({RA1, RA2, WA, data_in} !== 20'd0 ||
        {write_enable, done, err, zero, carry, instr_ready} !== 6'b000001) errors++;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [15:0] prog [13] = '{16'h8105, 16'h8203, 16'h1312, 16'h2421, 16'h86FF, 16'h8701,
                               16'h1867, 16'h3B61, 16'h4D12, 16'h5C12, 16'h6E12, 16'h7F62,
                               16'h0000};
    obs_t o;
    exp_t e;
    foreach (prog[i]) begin
      applyStimulus(prog[i], o);
      e = sb.pop_front();
      checks++;
      if (o.lat !== e.lat) begin
        errors++;
        $display("[TB] FAIL alu_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat);
      end
      checks++;
      if (o.we !== e.writes || o.err !== e.err) begin
        errors++;
        $display("[TB] FAIL alu_strobes[%0d]: got we=%b err=%b expected we=%b err=%b",
                 i, o.we, o.err, e.writes, e.err);
      end
      if (e.writes) begin
        checks++;
        if ({o.wa, o.data} !== {e.wa, e.data}) begin
          errors++;
          $display("[TB] FAIL alu_wb[%0d]: got WA=%h data=%h expected WA=%h data=%h",
                   i, o.wa, o.data, e.wa, e.data);
        end
      end
      checks++;
      if ({o.z, o.c} !== {e.z, e.c}) begin
        errors++;
        $display("[TB] FAIL alu_flags[%0d]: got z=%b c=%b expected z=%b c=%b",
                 i, o.z, o.c, e.z, e.c);
      end
      checks++;
      if (o.stray || o.after || !o.ready) begin
        errors++;
        $display("[TB] FAIL alu_handshake[%0d]: got stray=%b after=%b ready=%b expected 0 0 1",
                 i, o.stray, o.after, o.ready);
      end
      if (e.writes) shadow[e.wa] = e.data;
      expZ = e.z;
      expC = e.c;
    end
  endtask

  task automatic test_mul();
    logic [15:0] prog [3] = '{16'h9512, 16'h9966, 16'h9311};
    obs_t o;
    exp_t e;
    foreach (prog[i]) begin
      applyStimulus(prog[i], o);
      e = sb.pop_front();
      checks++;
      if (o.lat !== e.lat) begin
        errors++;
        $display("[TB] FAIL mul_latency[%0d]: got %0d expected %0d", i, o.lat, e.lat);
      end
      checks++;
      if ({o.we, o.wa, o.data} !== {1'b1, e.wa, e.data}) begin
        errors++;
        $display("[TB] FAIL mul_wb[%0d]: got we=%b WA=%h data=%h expected we=1 WA=%h data=%h",
                 i, o.we, o.wa, o.data, e.wa, e.data);
      end
      checks++;
      if ({o.z, o.c} !== {e.z, e.c}) begin
        errors++;
        $display("[TB] FAIL mul_flags[%0d]: got z=%b c=%b expected z=%b c=%b",
                 i, o.z, o.c, e.z, e.c);
      end
      checks++;
      if (o.stray || o.after || !o.ready) begin
        errors++;
        $display("[TB] FAIL mul_handshake[%0d]: got stray=%b after=%b ready=%b expected 0 0 1",
                 i, o.stray, o.after, o.ready);
      end
      shadow[e.wa] = e.data;
      expZ = e.z;
      expC = e.c;
    end
  endtask

  task automatic test_illegal();
    logic [15:0] prog [2] = '{16'hF123, 16'hA412};
    obs_t o;
    exp_t e;
    foreach (prog[i]) begin
      applyStimulus(prog[i], o);
      e = sb.pop_front();
      checks++;
      if ({o.lat, o.err, o.we} !== {32'(e.lat), 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL illegal_pulse[%0d]: got lat=%0d err=%b we=%b expected lat=%0d err=1 we=0",
                 i, o.lat, o.err, o.we, e.lat);
      end
      checks++;
      if ({o.z, o.c} !== {expZ, expC}) begin
        errors++;
        $display("[TB] FAIL illegal_flags[%0d]: got z=%b c=%b expected z=%b c=%b",
                 i, o.z, o.c, expZ, expC);
      end
      checks++;
      if (o.stray || o.after || rf[prog[i][11:8]] !== shadow[prog[i][11:8]]) begin
        errors++;
        $display("[TB] FAIL illegal_nowrite[%0d]: got stray=%b after=%b rd=%h expected 0 0 %h",
                 i, o.stray, o.after, rf[prog[i][11:8]], shadow[prog[i][11:8]]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seenWe;
    obs_t o;
    exp_t e;
    instr = 16'h9A12;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({RA1, RA2, WA, data_in, write_enable, done, err, zero, carry, instr_ready} !== 26'd1) begin
      errors++;
      $display("[TB] FAIL midmul_reset_outputs: got %h expected 0000001",
               {RA1, RA2, WA, data_in, write_enable, done, err, zero, carry, instr_ready});
    end
    instr = 16'h8AFF;
    instr_valid = 1'b1;
    seenWe = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (write_enable) seenWe = 1'b1;
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (write_enable || done) seenWe = 1'b1;
    end
    checks++;
    if (seenWe || !instr_ready || rf[10] !== shadow[10]) begin
      errors++;
      $display("[TB] FAIL midmul_dropped: got we_seen=%b ready=%b r10=%h expected 0 1 %h",
               seenWe, instr_ready, rf[10], shadow[10]);
    end
    expZ = 1'b0;
    expC = 1'b0;
    sb.delete();
    applyStimulus(16'h8A2A, o);
    e = sb.pop_front();
    checks++;
    if ({o.lat, o.we, o.wa, o.data, o.z, o.c} !== {32'(e.lat), 1'b1, e.wa, e.data, e.z, e.c}) begin
      errors++;
      $display("[TB] FAIL midmul_next_ldi: got lat=%0d we=%b WA=%h data=%h z=%b c=%b expected lat=%0d we=1 WA=%h data=%h z=%b c=%b",
               o.lat, o.we, o.wa, o.data, o.z, o.c, e.lat, e.wa, e.data, e.z, e.c);
    end
    shadow[e.wa] = e.data;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    expZ = 1'b0;
    expC = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'd0;
      shadow[i] = 8'd0;
    end
    test_reset();
    test_alu();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_exec_seq.md
Name: reg_exec_seq

Overview:
- Execute/control stage that sits directly upstream of the 16 x 8-bit register file and is its only reader and writer.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Drives the file's two read ports and samples both operands, computes the result (multiply is iterative, multi-cycle), then writes the result back through the file's write port.
- Reports completion, zero/carry flags and illegal opcodes.

Parameters:
- DATA_W, 8, register/operand width; must equal the register file data width.
- ADDR_W, 4, register address width; the file has 2^ADDR_W entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- instr  in  16  op[15:12], rd[11:8], rs1[7:4], rs2[3:0]; imm = instr[7:0].
- instr_valid  in  1  instr is present.
- instr_ready  out  1  high only in IDLE.
- RA1  out  ADDR_W  register file read address 1.
- RA2  out  ADDR_W  register file read address 2.
- data_out1  in  DATA_W  register file read data 1 (combinational from RA1).
- data_out2  in  DATA_W  register file read data 2 (combinational from RA2).
- WA  out  ADDR_W  write address.
- data_in  out  DATA_W  write data.
- write_enable  out  1  write strobe; the file captures data on the rising edge where this is high.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse on an illegal opcode.
- zero, carry  out  1  flags; registered, updated only by writing ops.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - RA1, RA2, WA and data_in are 0.
  - write_enable, done, err, zero and carry are 0.
  - Any in-flight instruction is dropped with no write. instr_valid is ignored while reset is asserted.
- FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE: instr_ready=1. Transfer occurs on a rising edge with instr_valid=1 -> latch instr, go to READ.
- READ (1 cycle): RA1=rs1, RA2=rs2 held stable. Go to EXEC.
- EXEC (1 cycle): sample data_out1/data_out2 as A/B and compute:
  - 0 NOP: no write. done pulses in this cycle, then IDLE.
  - 1 ADD: A+B; carry = bit DATA_W of the sum.
  - 2 SUB: A-B; carry = borrow (A<B).
  - 3 AND, 4 OR, 5 XOR: bitwise; carry=0.
  - 6 SHL: A<<B[2:0]; carry=0.
  - 7 SHR: logical A>>B[2:0]; carry=0.
  - 8 LDI: result = imm; carry=0; operands unused.
  - 9 MUL: go to MUL.
  - 10-15 illegal: err and done pulse in this cycle; no write; flags unchanged; then IDLE.
  - For ops 1-8, go to WB.
- MUL: shift-add for exactly DATA_W cycles (one multiplier bit per cycle, LSB first), with a 2*DATA_W accumulator.
  - result = low DATA_W bits; carry = (high half != 0).
  - Then go to WB.
- WB (1 cycle): write_enable=1, WA=rd, data_in=result. done=1.
  - zero=(result==0) and carry latch on the rising edge that ends WB.
  - Then go to IDLE.
- write_enable is high only in WB, never in any other state.
- Latency, counting the accept edge as cycle 0:
  - READ = cycle 1, EXEC = cycle 2, WB/done = cycle 3; instr_ready returns in cycle 4.
  - MUL: MUL occupies cycles 3-10, WB = cycle 11.
- Widths: all arithmetic is mod 2^DATA_W; rd=rs allowed. A write lands before the next instruction's READ, so there is no hazard.

Test Plan:
- Reset, LDI r1,5; LDI r2,3 -> write_enable in cycle 3 with WA=1/data_in=5, then WA=2/data_in=3; zero=0.
- ADD r3,r1,r2 -> WA=3, data_in=8, carry=0; done in cycle 3. SUB r4,r2,r1 -> data_in=0xFE, carry=1.
- LDI r6,0xFF; LDI r7,1; ADD r8,r6,r7 -> data_in=0x00, zero=1, carry=1.
- MUL r5,r1,r2 -> data_in=15 with WB in cycle 11; carry=0. MUL r9,r6,r6 -> data_in=0x01, carry=1.
- Opcode 0xF -> err and done pulse in cycle 2; write_enable stays 0; flags unchanged.
- Assert reset during cycle 5 of a MUL -> outputs 0 immediately, no write; after release, instr_ready=1 and the next LDI completes normally.
